// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, state encoding and baud-divisor helper
package uart_pkg;
   localparam int UART_DATA_BITS  = 8;
   localparam int UART_FRAME_BITS = 10;
   typedef enum logic {IDLE, SHIFT} uart_tx_state_t;
   function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction
endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts 0..COUNT-1 while enabled and pulses o_tc on the last count
// Ports: clk, rst (async, active-high), i_enable (count this cycle),
//        i_clear (force count to 0), o_tc (terminal-count pulse, combinational)
module uart_baud_counter #(
   parameter int COUNT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_enable,
   input  logic i_clear,
   output logic o_tc
);
   localparam int W = $clog2(COUNT);
   logic [W-1:0] r_count;
   assign o_tc = i_enable && (r_count == W'(COUNT - 1));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_count <= '0;
      else if (i_clear || o_tc) r_count <= '0;
      else if (i_enable) r_count <= r_count + 1'b1;
   end
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART transmitter with a one-byte holding register
// Ports: clk, reset (async, active-high), data_in/data_in_valid/data_in_ready
//        (ready/valid byte input), serial_out (TX line, idle high, driven from a flop)
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_in_ready,
   output logic       serial_out
);
   localparam int SET = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
   uart_tx_state_t r_state, w_next_state;
   logic [UART_DATA_BITS-1:0] r_hold;
   logic r_hold_full;
   logic [UART_DATA_BITS:0] r_shift;
   logic [3:0] r_bit;
   logic r_tx;
   logic w_tc, w_last, w_load, w_handshake;
   assign data_in_ready = ~r_hold_full;
   assign serial_out = r_tx;
   assign w_handshake = data_in_valid && ~r_hold_full;
   uart_baud_counter #(.COUNT(SET)) u_baud (
      .clk      (clk),
      .rst      (reset),
      .i_enable (r_state == SHIFT),
      .i_clear  (w_load),
      .o_tc     (w_tc)
   );
   // The shifter is free either when idle or on the final edge of the stop bit,
   // which lets a queued byte start with no idle gap.
   always_comb begin
      w_last = (r_state == SHIFT) && w_tc && (r_bit == 4'(UART_FRAME_BITS - 1));
      w_load = ((r_state == IDLE) || w_last) && r_hold_full;
      w_next_state = ((r_state == IDLE) || w_last) ? (r_hold_full ? SHIFT : IDLE) : r_state;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else r_state <= w_next_state;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_shift     <= '1;
         r_bit       <= '0;
         r_tx        <= 1'b1;
      end else begin
         if (w_handshake) begin
            r_hold      <= data_in;
            r_hold_full <= 1'b1;
         end else if (w_load) r_hold_full <= 1'b0;
         // r_shift holds the bits still to go (data then stop); r_tx is the bit on the wire.
         if (w_load) begin
            r_shift <= {1'b1, r_hold};
            r_tx    <= 1'b0;
            r_bit   <= '0;
         end else if (w_last) begin
            r_tx  <= 1'b1;
            r_bit <= '0;
         end else if (w_tc) begin
            r_tx    <= r_shift[0];
            r_shift <= {1'b1, r_shift[UART_DATA_BITS:1]};
            r_bit   <= r_bit + 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed and random stimulus checked against a frame-timing model
module tb_uart_transmitter;
   localparam int SET = 10;
   localparam int FRAME_CYCLES = SET * 10;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [7:0] data_in = '0;
   logic data_in_valid = 1'b0;
   logic data_in_ready, serial_out;
   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   bit m_hold_full = 0;
   logic [7:0] m_hold = '0;
   bit m_busy = 0;
   int m_start = 0;
   logic [7:0] m_byte = '0;
   uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
      .clk           (clk),
      .reset         (reset),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_in_ready (data_in_ready),
      .serial_out    (serial_out)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask
   function automatic logic exp_line();
      logic [9:0] f;
      f = {1'b1, m_byte, 1'b0};
      return m_busy ? f[(cyc - m_start) / SET] : 1'b1;
   endfunction
   task automatic model_reset();
      m_busy = 0;
      m_hold_full = 0;
   endtask
   task automatic model_edge(input bit hs, input logic [7:0] d);
      if (m_busy && (cyc - m_start) == FRAME_CYCLES) m_busy = 0;
      if (!m_busy && m_hold_full) begin
         m_busy = 1;
         m_start = cyc;
         m_byte = m_hold;
         m_hold_full = 0;
      end
      if (hs) begin
         m_hold_full = 1;
         m_hold = d;
      end
   endtask
   task automatic step();
      bit hs;
      logic [7:0] d;
      hs = !reset && data_in_valid && !m_hold_full;
      d = data_in;
      @(posedge clk);
      cyc++;
      if (reset) model_reset();
      else model_edge(hs, d);
      #1;
      chk("tx", {7'd0, serial_out}, {7'd0, exp_line()});
      chk("ready", {7'd0, data_in_ready}, {7'd0, !m_hold_full});
   endtask
   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask
   task automatic send(input logic [7:0] b);
      data_in = b;
      data_in_valid = 1'b1;
      step();
      data_in_valid = 1'b0;
   endtask
   initial begin
      steps(3);
      reset = 1'b0;
      steps(50);
      send(8'hA5);
      steps(110);
      send(8'h00);
      steps(20);
      send(8'hFF);
      steps(200);
      send(8'h33);
      steps(5);
      send(8'h44);
      data_in_valid = 1'b1;
      for (int i = 0; i < 400 && m_hold_full; i++) begin
         data_in = i[0] ? 8'h22 : 8'h11;
         step();
      end
      data_in = 8'h22;
      step();
      data_in_valid = 1'b0;
      data_in = 8'h11;
      steps(250);
      send(8'h3C);
      steps(36);
      #1;
      reset = 1'b1;
      #1;
      model_reset();
      chk("reset_tx", {7'd0, serial_out}, 8'd1);
      chk("reset_ready", {7'd0, data_in_ready}, 8'd1);
      steps(3);
      reset = 1'b0;
      steps(150);
      send(8'h80);
      steps(110);
      for (int i = 0; i < 2500; i++) begin
         data_in_valid = ($urandom_range(0, 7) == 0);
         data_in = 8'($urandom);
         step();
      end
      data_in_valid = 1'b0;
      steps(220);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
